// File: rtl/axi_mem_master.sv
// AXI4 master bridge for a stalling CPU memory port: one INCR burst (read or write) at a time,
// with sticky error reporting on bad responses, ID mismatches and RLAST/length disagreement.
module axi_mem_master #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ID_W      = 4,
  parameter int unsigned MASTER_ID = 0,
  parameter int unsigned LEN_W     = 4
) (
  input  logic                clk,
  input  logic                rst,
  // CPU side
  input  logic                req_i,
  input  logic                we_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [LEN_W-1:0]    len_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] wstrb_i,
  input  logic                wdata_valid_i,
  output logic                wdata_ready_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                rvalid_o,
  output logic                stall_o,
  output logic                done_o,
  output logic                err_o,
  // AR channel
  output logic [ID_W-1:0]     arid_m_o,
  output logic [ADDR_W-1:0]   araddr_m_o,
  output logic [7:0]          arlen_m_o,
  output logic [2:0]          arsize_m_o,
  output logic [1:0]          arburst_m_o,
  output logic                arvalid_m_o,
  input  logic                arready_m_i,
  // R channel
  input  logic [ID_W-1:0]     rid_m_i,
  input  logic [DATA_W-1:0]   rdata_m_i,
  input  logic [1:0]          rresp_m_i,
  input  logic                rlast_m_i,
  input  logic                rvalid_m_i,
  output logic                rready_m_o,
  // AW channel
  output logic [ID_W-1:0]     awid_m_o,
  output logic [ADDR_W-1:0]   awaddr_m_o,
  output logic [7:0]          awlen_m_o,
  output logic [2:0]          awsize_m_o,
  output logic [1:0]          awburst_m_o,
  output logic                awvalid_m_o,
  input  logic                awready_m_i,
  // W channel
  output logic [DATA_W-1:0]   wdata_m_o,
  output logic [DATA_W/8-1:0] wstrb_m_o,
  output logic                wlast_m_o,
  output logic                wvalid_m_o,
  input  logic                wready_m_i,
  // B channel
  input  logic [ID_W-1:0]     bid_m_i,
  input  logic [1:0]          bresp_m_i,
  input  logic                bvalid_m_i,
  output logic                bready_m_o
);

  localparam logic [ID_W-1:0] Mid  = ID_W'(MASTER_ID);
  localparam logic [2:0]      Size = 3'($clog2(DATA_W / 8));

  typedef enum logic [2:0] {StIdle, StRaddr, StRbeat, StWaddr, StWbeat, StWresp} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    beat_q, beat_d;
  logic                err_q, err_d;
  logic                done_q, done_d;
  logic                last_beat;

  assign last_beat   = (beat_q == len_q);

  assign arid_m_o    = Mid;
  assign awid_m_o    = Mid;
  assign arsize_m_o  = Size;
  assign awsize_m_o  = Size;
  assign arburst_m_o = 2'b01;
  assign awburst_m_o = 2'b01;
  assign arlen_m_o   = 8'(len_q);
  assign awlen_m_o   = 8'(len_q);

  assign rdata_o       = rdata_m_i;
  assign rvalid_o      = rvalid_m_i & rready_m_o;
  assign wdata_ready_o = wvalid_m_o & wready_m_i;
  assign stall_o       = (state_q != StIdle) | req_i;
  assign done_o        = done_q;
  assign err_o         = err_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    beat_d      = beat_q;
    err_d       = err_q;
    done_d      = 1'b0;
    araddr_m_o  = '0;
    arvalid_m_o = 1'b0;
    rready_m_o  = 1'b0;
    awaddr_m_o  = '0;
    awvalid_m_o = 1'b0;
    wdata_m_o   = '0;
    wstrb_m_o   = '0;
    wlast_m_o   = 1'b0;
    wvalid_m_o  = 1'b0;
    bready_m_o  = 1'b0;
    case (state_q)
      StIdle: begin
        if (req_i) begin
          addr_d  = addr_i;
          len_d   = len_i;
          beat_d  = '0;
          err_d   = 1'b0;
          state_d = we_i ? StWaddr : StRaddr;
        end
      end
      StRaddr: begin
        arvalid_m_o = 1'b1;
        araddr_m_o  = addr_q;
        if (arready_m_i) state_d = StRbeat;
      end
      StRbeat: begin
        rready_m_o = 1'b1;
        if (rvalid_m_i) begin
          // Counter wraps on overrun; only RLAST ends the burst.
          beat_d = beat_q + LEN_W'(1);
          if ((rresp_m_i != 2'b00) || (rid_m_i != Mid) || (rlast_m_i != last_beat)) begin
            err_d = 1'b1;
          end
          if (rlast_m_i) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      StWaddr: begin
        awvalid_m_o = 1'b1;
        awaddr_m_o  = addr_q;
        if (awready_m_i) state_d = StWbeat;
      end
      StWbeat: begin
        wvalid_m_o = wdata_valid_i;
        wdata_m_o  = wdata_i;
        wstrb_m_o  = wstrb_i;
        wlast_m_o  = last_beat;
        if (wdata_valid_i && wready_m_i) begin
          beat_d = beat_q + LEN_W'(1);
          if (last_beat) state_d = StWresp;
        end
      end
      StWresp: begin
        bready_m_o = 1'b1;
        if (bvalid_m_i) begin
          if ((bresp_m_i != 2'b00) || (bid_m_i != Mid)) err_d = 1'b1;
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: doc/axi_mem_master.md
# axi_mem_master

Parametrised AXI4 master bridge between a CPU memory port (instruction fetch or load/store) and one master port of the AXI interconnect. It generalises the single-beat, read-only fetch wrapper: INCR bursts of 1..2^LEN_W beats, full read and write channels, configurable widths and master ID, and response-error reporting. One request is handled at a time. The CPU is stalled from request until completion.

## Interface
- ADDR_W, 32: address width
- DATA_W, 32: data width; power of two, 8..1024
- ID_W, 4: AXI ID width
- MASTER_ID, 0: constant driven on ARID/AWID; RID/BID are checked against it
- LEN_W, 4: burst-length field width; beats = len_i+1

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req_i  in  1  request strobe, sampled in IDLE
- we_i  in  1  1 = write burst, 0 = read burst
- addr_i  in  ADDR_W  start address, DATA_W/8-aligned
- len_i  in  LEN_W  beats minus one
- wdata_i / wstrb_i  in  DATA_W / DATA_W/8  write beat data/strobes
- wdata_valid_i  in  1  CPU has a write beat available
- wdata_ready_o  out  1  write beat consumed this cycle
- rdata_o  out  DATA_W  read beat data (RDATA passthrough)
- rvalid_o  out  1  read beat delivered this cycle
- stall_o  out  1  CPU must hold
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  last transaction had an error
- AR*_M (ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID / ARREADY in); R*_M (RID, RDATA, RRESP, RLAST, RVALID in / RREADY out)
- AW*_M, W*_M (WDATA, WSTRB, WLAST, WVALID / WREADY in), B*_M (BID, BRESP, BVALID in / BREADY out): standard AXI4 widths per parameters

## Operation
- States: IDLE, RADDR, RBEAT, WADDR, WBEAT, WRESP.
- IDLE + req_i: capture addr/len/we, clear err, go to RADDR (we=0) or WADDR (we=1).
- RADDR: ARVALID=1, ARADDR/ARLEN = captured values. Go to RBEAT on ARREADY.
- RBEAT: RREADY=1. Each RVALID beat increments beat_cnt. The RLAST beat goes to IDLE.
- WADDR: AWVALID=1. Go to WBEAT on AWREADY. W is never issued before the AW handshake.
- WBEAT:
  - WVALID = wdata_valid_i; WDATA/WSTRB pass through.
  - WLAST = (beat_cnt == len).
  - wdata_ready_o = WVALID & WREADY.
  - The last beat accepted goes to WRESP.
- WRESP: BREADY=1. BVALID goes to IDLE.
- Constant fields:
  - ARID = AWID = MASTER_ID.
  - ARSIZE = AWSIZE = log2(DATA_W/8).
  - ARBURST = AWBURST = INCR (2'b01).
- Outside their states, ARADDR, AWADDR, WDATA and WSTRB are driven 0.
- Valid signals are held until the handshake. Address and len are stable while valid.
- rvalid_o = RVALID & RREADY.
- Error sources; err_o is set sticky and cleared on the next accepted request:
  - RRESP or BRESP != OKAY
  - RID or BID != MASTER_ID
  - RLAST arrives while beat_cnt != len
  - beat_cnt == len without RLAST
- Overrun: if RLAST never comes, beats past len still count, modulo 2^LEN_W. The FSM exits only on RLAST.
- stall_o = (state != IDLE) | req_i. This is combinational, so the request cycle stalls too.
- done_o is registered. It is high for exactly the first IDLE cycle after completion.
- A new req_i in that same cycle is accepted.

## Timing
- Reset (rst=0) forces:
  - state IDLE, beat_cnt 0
  - all VALID/READY outputs 0, done_o 0, err_o 0, address/data outputs 0
- Reset mid-burst abandons the transaction and issues no further beats.
- Read, zero wait states, req at cycle t:
  - ARVALID at t+1
  - RREADY at t+2, single beat accepted at t+2
  - done_o and IDLE at t+3
- Read latency = 3 + ARREADY waits + R-beat gaps + len.
- Write, zero wait states, len=0:
  - AWVALID t+1, WVALID t+2, BREADY t+3
  - done_o at t+4
- Simultaneous ARREADY and early RVALID in RADDR: RVALID is ignored because RREADY=0. The slave must hold it.

## Test plan
- Single read: addr 0x100, len 0, ARREADY immediate, RDATA 0xDEADBEEF with RLAST -> ARLEN=0, ARSIZE=2, rvalid_o once with 0xDEADBEEF, done_o at t+3, err_o=0.
- 4-beat read with ARREADY delayed 2 cycles and one RVALID gap: addr 0x200, len 3 -> ARVALID held 3 cycles, 4 rvalid_o pulses in order, done_o after the RLAST beat.
- 2-beat write with wdata_valid_i low for 1 cycle and WREADY low for 1 cycle: addr 0x40, len 1 -> WVALID follows wdata_valid_i, WLAST only on beat 2, BREADY then done_o, err_o=0.
- Error responses: RRESP=SLVERR on beat 1 of 2 -> err_o=1 at done_o. A BID mismatch on a write also gives err_o=1. A following clean request clears err_o.
- Early RLAST on beat 2 of len=3 -> FSM returns to IDLE, done_o pulses, err_o=1.
- Reset asserted mid-RBEAT, then back-to-back requests in the done_o cycle -> all outputs 0 during reset; afterwards the second request is accepted in the done_o cycle, with ARVALID the next cycle.
